// File: rtl/nfsr_stream_decryptor.sv
`default_nettype none
// ============================================================================
//  Module      : nfsr_stream_decryptor
//  Description : Receiver-side 80-bit NFSR stream decryptor. Loads a seed,
//                runs a free-running warm-up, then XORs each accepted
//                ciphertext bit with one keystream bit into a one-entry
//                valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module nfsr_stream_decryptor #(
  parameter int WARMUP = 160,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             start,
  input  logic [79:0]      seed,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARMUP);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [79:0]        s_q, s_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic               out_bit_q, out_bit_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_c;
  logic               feedback;
  logic [79:0]        s_shift;

  // Nonlinear feedback and the one-step-advanced register image
  always_comb begin
    feedback = s_q[0] ^ s_q[5] ^ s_q[6] ^ s_q[9] ^ s_q[17] ^ s_q[22]
             ^ (s_q[4] & s_q[13])
             ^ (s_q[8] & s_q[16])
             ^ (s_q[5] & s_q[11] & s_q[14])
             ^ (s_q[2] & s_q[5] & s_q[8] & s_q[10]);
    s_shift  = {feedback, s_q[79:1]};
  end

  // Next-state, datapath and handshake logic
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    remaining_d = remaining_q;
    warm_cnt_d  = warm_cnt_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    in_ready_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          s_d         = seed;
          remaining_d = frame_len;
          warm_cnt_d  = WARM_INIT;
          state_d     = (WARMUP > 0) ? S_WARMUP : S_STREAM;
        end
      end

      S_WARMUP: begin
        s_d        = s_shift;
        warm_cnt_d = warm_cnt_q - WARM_LAST;
        if (warm_cnt_q == WARM_LAST) begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        // Accept only when a slot is free now or is being drained this cycle
        in_ready_c = (remaining_q != '0) && (!out_valid_q || out_ready);
        if (in_valid && in_ready_c) begin
          out_bit_d   = in_bit ^ s_q[0];
          out_valid_d = 1'b1;
          s_d         = s_shift;
          remaining_d = remaining_q - 1'b1;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if ((remaining_q == '0) && !out_valid_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous abort to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      s_q         <= '0;
      remaining_q <= '0;
      warm_cnt_q  <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      remaining_q <= remaining_d;
      warm_cnt_q  <= warm_cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire
